stop_watch_lap_ctrl: RTL and testbench

Parametrised stopwatch controller with integrated time base, time counter and lap memory. Two debounced single-cycle key pulses drive a four-state machine (stop, run, pause, lap-freeze). The block produces a display value, status flags and a random-read lap buffer. It sits between the key debouncers and the display/BCD conversion path.

---
 rtl/stop_watch_pkg.sv | 10 +
 rtl/stop_watch_prescaler.sv | 22 ++
 rtl/stop_watch_lap_ctrl.sv | 109 ++++++++++
 tb/tb_stop_watch_lap_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/stop_watch_pkg.sv
// stop_watch_pkg: one-hot state encoding and key decode shared by the stopwatch blocks
package stop_watch_pkg;
    typedef enum logic [3:0] {STOP = 4'h1, RUN = 4'h2, PAUSE = 4'h4, FREEZE = 4'h8} sw_state_t;
    typedef enum logic [1:0] {KEY_NONE = 2'd0, KEY_START = 2'd1, KEY_LAP = 2'd2} key_t;

    // k0 wins when both keys arrive on the same edge
    function automatic key_t decode_key(input logic k0, input logic k1);
        return k0 ? KEY_START : (k1 ? KEY_LAP : KEY_NONE);
    endfunction
endpackage

// File: rtl/stop_watch_prescaler.sv
// stop_watch_prescaler: divides clk by TICK_DIV while enabled, one-cycle tick on wrap
module stop_watch_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] cnt;

    assign tick = enable && cnt == PW'(TICK_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/stop_watch_lap_ctrl.sv
// stop_watch_lap_ctrl: stopwatch FSM, time counter, lap memory and display register.
// Define STOP_WATCH_SAT_EN to saturate the counter instead of wrapping.
module stop_watch_lap_ctrl #(
    parameter int TIME_W    = 24,
    parameter int TICK_DIV  = 1000,
    parameter int LAP_DEPTH = 4,
    localparam int IDX_W    = LAP_DEPTH > 1 ? $clog2(LAP_DEPTH) : 1,
    localparam int CNT_W    = $clog2(LAP_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              k0,
    input  logic              k1,
    input  logic [IDX_W-1:0]  lap_rd_idx,
    output logic [TIME_W-1:0] time_o,
    output logic              running,
    output logic              frozen,
    output logic [CNT_W-1:0]  lap_cnt,
    output logic              lap_full,
    output logic              lap_drop,
    output logic [TIME_W-1:0] lap_rd_data,
    output logic              overflow
);
    import stop_watch_pkg::*;

    sw_state_t         state;
    key_t              key;
    logic [TIME_W-1:0] cnt, cap;
    logic [TIME_W-1:0] mem [LAP_DEPTH];
    logic [CNT_W-1:0]  lap_n;
    logic              tick, is_run, full, do_cap, do_clr, drop_q;

    assign key    = decode_key(k0, k1);
    assign is_run = state == RUN || state == FREEZE;
    assign full   = lap_n == CNT_W'(LAP_DEPTH);
    assign do_cap = key == KEY_LAP && is_run;
    assign do_clr = key == KEY_LAP && state == PAUSE;

    stop_watch_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (is_run),
        .clear  (do_clr),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= STOP;
            cap    <= '0;
            lap_n  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= do_cap && full;
            if (key == KEY_START) state <= state == RUN ? PAUSE : RUN;
            else if (do_cap) begin
                state <= FREEZE;
                cap   <= cnt;
                if (!full) lap_n <= lap_n + 1'b1;
            end else if (do_clr) begin
                state <= STOP;
                lap_n <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (do_clr) begin
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (tick) begin
`ifdef STOP_WATCH_SAT_EN
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (cnt == ~TIME_W'(1)) overflow <= 1'b1;
`else
            cnt <= cnt + 1'b1;
            if (cnt == '1) overflow <= 1'b1;
`endif
        end
    end

    // lap storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (do_cap && !full) mem[lap_n[IDX_W-1:0]] <= cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_o      <= '0;
            running     <= 1'b0;
            frozen      <= 1'b0;
            lap_cnt     <= '0;
            lap_full    <= 1'b0;
            lap_drop    <= 1'b0;
            lap_rd_data <= '0;
        end else begin
            time_o      <= state == FREEZE ? cap : cnt;
            running     <= is_run;
            frozen      <= state == FREEZE;
            lap_cnt     <= lap_n;
            lap_full    <= full;
            lap_drop    <= drop_q;
            lap_rd_data <= int'(lap_rd_idx) < LAP_DEPTH ? mem[lap_rd_idx] : '0;
        end
    end
endmodule

// File: tb/tb_stop_watch_lap_ctrl.sv
// tb_stop_watch_lap_ctrl: random and directed key stimulus against an elapsed-time reference model
module tb_stop_watch_lap_ctrl;
    localparam int TW = 8, TD = 4, LD = 2;
`ifdef STOP_WATCH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, k0 = 1'b0, k1 = 1'b0;
    logic [0:0]    lap_rd_idx = 1'b0;
    logic [TW-1:0] time_o, lap_rd_data;
    logic [1:0]    lap_cnt;
    logic          running, frozen, lap_full, lap_drop, overflow;

    stop_watch_lap_ctrl #(.TIME_W(TW), .TICK_DIV(TD), .LAP_DEPTH(LD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .k0          (k0),
        .k1          (k1),
        .lap_rd_idx  (lap_rd_idx),
        .time_o      (time_o),
        .running     (running),
        .frozen      (frozen),
        .lap_cnt     (lap_cnt),
        .lap_full    (lap_full),
        .lap_drop    (lap_drop),
        .lap_rd_data (lap_rd_data),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int time_o, running, frozen, lap_cnt, lap_full, lap_drop, overflow, rd_ok, rd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;

    // model: mode 0=stop 1=run 2=pause 3=freeze; t counts clk cycles spent running since clear
    int mode = 0, t = 0, lapn = 0, cap = 0, drop_ev = 0;
    int mem[LD];

    function automatic int ticks();
        return t / TD;
    endfunction

    function automatic int shown();
        return SAT ? (ticks() > 2**TW - 1 ? 2**TW - 1 : ticks()) : ticks() % (2**TW);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_chk();
        chk("rst time_o", int'(time_o), 0);
        chk("rst running", int'(running), 0);
        chk("rst frozen", int'(frozen), 0);
        chk("rst lap_cnt", int'(lap_cnt), 0);
        chk("rst lap_full", int'(lap_full), 0);
        chk("rst lap_drop", int'(lap_drop), 0);
        chk("rst lap_rd_data", int'(lap_rd_data), 0);
        chk("rst overflow", int'(overflow), 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("time_o", int'(time_o), e.time_o);
            chk("running", int'(running), e.running);
            chk("frozen", int'(frozen), e.frozen);
            chk("lap_cnt", int'(lap_cnt), e.lap_cnt);
            chk("lap_full", int'(lap_full), e.lap_full);
            chk("lap_drop", int'(lap_drop), e.lap_drop);
            chk("overflow", int'(overflow), e.overflow);
            if (e.rd_ok != 0) chk("lap_rd_data", int'(lap_rd_data), e.rd);
        end
    end

    // called at a negedge: drive keys, model the next edge, return at the following negedge
    task automatic step(input bit a, input bit b, input int ix);
        exp_t e;
        int   cv;
        k0 = a; k1 = b; lap_rd_idx = 1'(ix);
        @(posedge clk);
        cv         = shown();
        e.time_o   = mode == 3 ? cap : cv;
        e.running  = int'(mode == 1 || mode == 3);
        e.frozen   = int'(mode == 3);
        e.lap_cnt  = lapn;
        e.lap_full = int'(lapn == LD);
        e.lap_drop = drop_ev;
        e.rd_ok    = int'(ix < lapn);
        e.rd       = mem[ix];
        drop_ev    = 0;
        if (mode == 1 || mode == 3) t++;
        if (a) mode = mode == 1 ? 2 : 1;
        else if (b && (mode == 1 || mode == 3)) begin
            cap  = cv;
            mode = 3;
            if (lapn < LD) begin
                mem[lapn] = cv;
                lapn++;
            end else drop_ev = 1;
        end else if (b && mode == 2) begin
            mode = 0; t = 0; lapn = 0;
        end
        e.overflow = int'(ticks() >= (SAT ? 2**TW - 1 : 2**TW));
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, int'($urandom_range(0, 1)));
    endtask

    task automatic mid_reset();
        k0 = 1'b0; k1 = 1'b0;
        #2 rst_n = 1'b0;
        #1 reset_chk();
        mode = 0; t = 0; lapn = 0; cap = 0; drop_ev = 0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #3 reset_chk();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0); idle(40);
        step(0, 1, 0); idle(8); step(1, 0, 0); idle(10);
        step(0, 1, 0); idle(12); step(0, 1, 1); idle(12); step(0, 1, 0); idle(6);
        step(1, 0, 0); step(1, 0, 0); idle(20); step(1, 0, 1); idle(10);
        step(1, 0, 0); step(0, 1, 0); idle(5);
        step(1, 0, 0); idle(1100);
        step(1, 1, 0); idle(3); step(1, 0, 1); idle(7);
        mid_reset(); idle(3);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 499));
            if (r == 0) mid_reset();
            else step(r < 12 || r == 499, (r >= 12 && r < 28) || r == 499, int'($urandom_range(0, 1)));
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
